// File: rtl/gate_sweep_ctrl.sv
// In-circuit sweep of a 2-input AND cell: drives 00,01,10,11 with a programmable
// dwell and compares the cell output. Optional macro GATE_SWEEP_HALT_ON_ERR_EN stops at first mismatch.
module gate_sweep_ctrl #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DWELL_W-1:0] dwell,
  output logic               a,
  output logic               b,
  input  logic               c,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2:0]         err_count,
  output logic [1:0]         fail_vec
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [1:0]         idx_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] dw_q;
  logic               err_seen_q;
  logic               a_q;
  logic               b_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic [2:0]         err_q;
  logic [1:0]         fail_q;

  logic               mismatch_c;
  logic [2:0]         err_d;
  logic               finish_c;

  // Compare-cycle decode: mismatch against the vector currently on the pins.
  always_comb begin
    mismatch_c = (c != (a_q & b_q));
    err_d      = err_q + 3'(mismatch_c);
    finish_c   = (idx_q == 2'd3);
`ifdef GATE_SWEEP_HALT_ON_ERR_EN
    if (mismatch_c) begin
      finish_c = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      cnt_q      <= '0;
      dw_q       <= '0;
      err_seen_q <= 1'b0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 3'd0;
      fail_q     <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q    <= ST_RUN;
            idx_q      <= 2'd0;
            cnt_q      <= dwell;
            dw_q       <= dwell;
            err_seen_q <= 1'b0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= 3'd0;
            fail_q     <= 2'd0;
          end
        end
        ST_RUN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - DWELL_W'(1);
          end else begin
            err_q <= err_d;
            if (mismatch_c && !err_seen_q) begin
              fail_q     <= idx_q;
              err_seen_q <= 1'b1;
            end
            if (finish_c) begin
              state_q <= ST_DONE;
              a_q     <= 1'b0;
              b_q     <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == 3'd0);
            end else begin
              idx_q        <= idx_q + 2'd1;
              {a_q, b_q}   <= idx_q + 2'd1;
              cnt_q        <= dw_q;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed self-checking bench for gate_sweep_ctrl; expectations follow GATE_SWEEP_HALT_ON_ERR_EN.
module tb_gate_sweep_ctrl;

  localparam int unsigned DWELL_W = 8;
  localparam int MODE_AND = 0;
  localparam int MODE_ONE = 1;
  localparam int MODE_OR  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [DWELL_W-1:0] dwell;
  logic               a;
  logic               b;
  logic               c;
  logic               busy;
  logic               done;
  logic               pass;
  logic [2:0]         err_count;
  logic [1:0]         fail_vec;

  int gate_mode;
  int errors;
  int checks;

  gate_sweep_ctrl #(.DWELL_W(DWELL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dwell     (dwell),
    .a         (a),
    .b         (b),
    .c         (c),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  always #5 clk = ~clk;

  // Model of the cell under test, selectable good or faulty.
  always_comb begin
    c = a & b;
    case (gate_mode)
      MODE_ONE: c = 1'b1;
      MODE_OR:  c = a | b;
      default:  c = a & b;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int d);
    start = 1'b1;
    dwell = DWELL_W'(d);
    step();
    start = 1'b0;
  endtask

  task automatic check_done(input string name, input logic [2:0] exp_err,
                            input logic [1:0] exp_fail, input logic exp_pass);
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || {a, b} !== 2'b00) begin
      errors++;
      $display("FAIL %s_end: busy=%b done=%b ab=%b required busy=0 done=1 ab=00",
               name, busy, done, {a, b});
    end
    checks++;
    if (err_count !== exp_err || fail_vec !== exp_fail || pass !== exp_pass) begin
      errors++;
      $display("FAIL %s_result: err=%0d fail=%0d pass=%b required err=%0d fail=%0d pass=%b",
               name, err_count, fail_vec, pass, exp_err, exp_fail, exp_pass);
    end
  endtask

  task automatic sweep_check(input string name, input int d, input int mode,
                             input int exp_cycles, input logic [2:0] exp_err,
                             input logic [1:0] exp_fail, input logic exp_pass);
    logic [1:0] exp_v;
    gate_mode = mode;
    do_start(d);
    for (int i = 0; i < exp_cycles; i++) begin
      exp_v = 2'(i / (d + 1));
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || {a, b} !== exp_v) begin
        errors++;
        $display("FAIL %s_cyc%0d: busy=%b done=%b ab=%b required busy=1 done=0 ab=%b",
                 name, i, busy, done, {a, b}, exp_v);
      end
      step();
    end
    check_done(name, exp_err, exp_fail, exp_pass);
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({a, b, busy, done, pass, err_count, fail_vec} !== 10'd0) begin
      errors++;
      $display("FAIL %s: ab=%b busy=%b done=%b pass=%b err=%0d fail=%0d required all 0",
               name, {a, b}, busy, done, pass, err_count, fail_vec);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    check_all_zero("reset_async");
    step();
    step();
    check_all_zero("reset_held");
    @(negedge clk);
    rst = 1'b0;
    step();
    check_all_zero("reset_idle");
  endtask

  task automatic test_and_sweeps();
    sweep_check("and_d0", 0, MODE_AND, 4, 3'd0, 2'd0, 1'b1);
    sweep_check("and_d3", 3, MODE_AND, 16, 3'd0, 2'd0, 1'b1);
  endtask

  task automatic test_faulty_gates();
`ifdef GATE_SWEEP_HALT_ON_ERR_EN
    sweep_check("stuck1_d1", 1, MODE_ONE, 2, 3'd1, 2'd0, 1'b0);
    sweep_check("or_d2", 2, MODE_OR, 6, 3'd1, 2'd1, 1'b0);
`else
    sweep_check("stuck1_d1", 1, MODE_ONE, 8, 3'd3, 2'd0, 1'b0);
    sweep_check("or_d2", 2, MODE_OR, 12, 3'd2, 2'd1, 1'b0);
`endif
  endtask

  task automatic test_reset_mid_run();
    gate_mode = MODE_AND;
    do_start(5);
    for (int i = 0; i < 13; i++) step();
    checks++;
    if (busy !== 1'b1 || {a, b} !== 2'b10) begin
      errors++;
      $display("FAIL rst_mid_pre: busy=%b ab=%b required busy=1 ab=10", busy, {a, b});
    end
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid_async");
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    check_all_zero("rst_mid_idle");
  endtask

  task automatic test_start_in_run();
    int n;
    gate_mode = MODE_AND;
    do_start(1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      start = (n == 2) ? 1'b1 : 1'b0;
      step();
      n++;
    end
    start = 1'b0;
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL start_in_run_len: busy_cycles=%0d required 8", n);
    end
    check_done("start_in_run", 3'd0, 2'd0, 1'b1);
  endtask

  task automatic test_restart_from_done();
`ifdef GATE_SWEEP_HALT_ON_ERR_EN
    sweep_check("pre_restart", 0, MODE_ONE, 1, 3'd1, 2'd0, 1'b0);
`else
    sweep_check("pre_restart", 0, MODE_ONE, 4, 3'd3, 2'd0, 1'b0);
`endif
    gate_mode = MODE_AND;
    do_start(0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || err_count !== 3'd0 ||
        {a, b} !== 2'b00) begin
      errors++;
      $display("FAIL restart_clear: busy=%b done=%b pass=%b err=%0d ab=%b required 1 0 0 0 00",
               busy, done, pass, err_count, {a, b});
    end
    for (int i = 0; i < 4; i++) step();
    check_done("restart", 3'd0, 2'd0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int n;
    gate_mode = MODE_AND;
    start = 1'b1;
    dwell = DWELL_W'(0);
    step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy !== 1'b1 || {a, b} !== 2'(i)) begin
        errors++;
        $display("FAIL b2b_run%0d: busy=%b ab=%b required busy=1 ab=%0d", i, busy, {a, b}, i);
      end
      step();
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || pass !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: busy=%b done=%b pass=%b required 0 1 1", busy, done, pass);
    end
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || {a, b} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_restart: busy=%b done=%b ab=%b required 1 0 00", busy, done, {a, b});
    end
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL b2b_second_len: cycles=%0d required 4", n);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    gate_mode = MODE_AND;
    start     = 1'b0;
    dwell     = '0;
    test_reset();
    test_and_sweeps();
    test_faulty_gates();
    test_reset_mid_run();
    test_start_in_run();
    test_restart_from_done();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
